// File: rtl/lc3b_types.sv
// lc3b_types: shared word/line types, arbiter state enum and line-address helper.
// No ports; imported by evict_drain_priority and evict_drain_arbiter.
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_line;
    typedef enum logic [1:0] {IDLE, DEMAND, DRAIN} lc3b_arb_state;
    function automatic lc3b_word line_addr(input lc3b_word a, input int off);
        return a >> off;
    endfunction
endpackage

// File: rtl/evict_drain_priority.sv
// evict_drain_priority: combinational winner select between demand read and drain write.
// Inputs: dem_read, drn_write, dem_address, drn_address, starve_cnt, dirty_count.
// Outputs: grant_dem, grant_drn (mutually exclusive, both low when nobody asks).
module evict_drain_priority import lc3b_types::*; #(
    parameter int ADDR_W       = 16,
    parameter int OFFSET_W     = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int HIGH_WATER   = 6
) (
    input  logic              dem_read,
    input  logic              drn_write,
    input  logic [ADDR_W-1:0] dem_address,
    input  logic [ADDR_W-1:0] drn_address,
    input  logic [2:0]        starve_cnt,
    input  logic [3:0]        dirty_count,
    output logic              grant_dem,
    output logic              grant_drn
);
    logic same_line, urgent;
    // A pending write-back to the same line must land before the read, or the read sees stale data.
    assign same_line = line_addr(lc3b_word'(dem_address), OFFSET_W) == line_addr(lc3b_word'(drn_address), OFFSET_W);
    assign urgent    = 32'(starve_cnt) >= STARVE_LIMIT || 32'(dirty_count) >= HIGH_WATER || same_line;
    assign grant_drn = drn_write && (!dem_read || urgent);
    assign grant_dem = dem_read && !grant_drn;
endmodule

// File: rtl/evict_drain_arbiter.sv
// evict_drain_arbiter: shares one physical-memory port between demand line reads and dirty-victim drains.
// Demand side: dem_read/dem_address in, dem_rdata/dem_resp out.
// Drain side: drn_write/drn_address/drn_wdata in, drn_resp out; dirty_count gives buffer occupancy.
// Memory side: pmem_read/pmem_write/pmem_address/pmem_wdata out, pmem_rdata/pmem_resp in.
module evict_drain_arbiter import lc3b_types::*; #(
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 128,
    parameter int OFFSET_W     = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int HIGH_WATER   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dem_read,
    input  logic [ADDR_W-1:0] dem_address,
    output logic [LINE_W-1:0] dem_rdata,
    output logic              dem_resp,
    input  logic              drn_write,
    input  logic [ADDR_W-1:0] drn_address,
    input  logic [LINE_W-1:0] drn_wdata,
    output logic              drn_resp,
    input  logic [3:0]        dirty_count,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    lc3b_arb_state     state, state_nx;
    logic [2:0]        starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              grant_dem, grant_drn;

    evict_drain_priority #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .STARVE_LIMIT(STARVE_LIMIT), .HIGH_WATER(HIGH_WATER)
    ) u_priority (
        .dem_read(dem_read), .drn_write(drn_write), .dem_address(dem_address), .drn_address(drn_address),
        .starve_cnt(starve_cnt), .dirty_count(dirty_count), .grant_dem(grant_dem), .grant_drn(grant_drn)
    );

    // Grants are taken only from IDLE and the address/data are frozen here for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && grant_dem) begin
                addr_q <= dem_address;
                if (drn_write && starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
            end
            if (state == IDLE && grant_drn) begin
                addr_q     <= drn_address;
                wdata_q    <= drn_wdata;
                starve_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        dem_resp   = 1'b0;
        drn_resp   = 1'b0;
        dem_rdata  = '0;
        case (state)
            IDLE:    state_nx = grant_drn ? DRAIN : grant_dem ? DEMAND : IDLE;
            DEMAND: begin
                pmem_read = 1'b1;
                dem_resp  = pmem_resp;
                dem_rdata = pmem_resp ? pmem_rdata : '0;
                state_nx  = pmem_resp ? IDLE : DEMAND;
            end
            DRAIN: begin
                pmem_write = 1'b1;
                drn_resp   = pmem_resp;
                state_nx   = pmem_resp ? IDLE : DRAIN;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
endmodule

// File: tb/tb_evict_drain_arbiter.sv
// tb_evict_drain_arbiter: directed and randomized checks of evict_drain_arbiter against a rule-level model.
module tb_evict_drain_arbiter;
    logic         clk = 0, rst_n = 0, dem_read = 0, drn_write = 0, pmem_resp = 0;
    logic [15:0]  dem_address = 0, drn_address = 0, pmem_address;
    logic [127:0] dem_rdata, drn_wdata = 0, pmem_wdata, pmem_rdata = 0;
    logic         dem_resp, drn_resp, pmem_read, pmem_write;
    logic [3:0]   dirty_count = 0;
    int checks = 0, errors = 0, m_starve = 0;

    evict_drain_arbiter dut (
        .clk(clk), .rst_n(rst_n), .dem_read(dem_read), .dem_address(dem_address), .dem_rdata(dem_rdata),
        .dem_resp(dem_resp), .drn_write(drn_write), .drn_address(drn_address), .drn_wdata(drn_wdata),
        .drn_resp(drn_resp), .dirty_count(dirty_count), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    // Model: 0 = no grant, 1 = demand, 2 = drain.
    function automatic int exp_kind(bit d, bit w, logic [15:0] da, logic [15:0] wa, int dirty);
        if (!d && !w) return 0;
        if (!w) return 1;
        if (!d) return 2;
        if (m_starve >= 4 || dirty >= 6 || da / 16 == wa / 16) return 2;
        return 1;
    endfunction

    task automatic m_grant(input int kind, input bit w);
        if (kind == 1 && w) m_starve = (m_starve == 7) ? 7 : m_starve + 1;
        if (kind == 2) m_starve = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; dem_read = 0; drn_write = 0; pmem_resp = 0; dirty_count = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        m_starve = 0;
    endtask

    // Memory responder: waits for a strobe, holds it lat cycles, answers on the last one.
    task automatic serve(input int lat, input logic [127:0] rd, input bit scr, output int kind,
                         output logic [15:0] addr, output logic [127:0] wd, output bit stable,
                         output bit dresp, output bit wresp, output logic [127:0] got);
        kind = 0; stable = 1; dresp = 0; wresp = 0; got = '0; addr = '0; wd = '0;
        for (int i = 0; i < 20 && kind == 0; i++) begin
            @(negedge clk);
            if (pmem_read) kind = 1; else if (pmem_write) kind = 2;
        end
        if (kind == 0) return;
        addr = pmem_address; wd = pmem_wdata;
        if (scr) begin
            dem_address = 16'($urandom); drn_address = 16'($urandom); drn_wdata = {4{$urandom}};
        end
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            if (k == lat) begin pmem_rdata = rd; pmem_resp = 1; end
            #1;
            if ((kind == 1) !== pmem_read || (kind == 2) !== pmem_write || pmem_address !== addr || pmem_wdata !== wd) stable = 0;
            if (k < lat && (dem_resp || drn_resp)) stable = 0;
            if (k == lat) begin dresp = dem_resp; wresp = drn_resp; got = dem_rdata; end
        end
        @(posedge clk); #1;
        pmem_resp = 0;
    endtask

    task automatic test_reset();
        do_reset();
        pmem_resp = 1; pmem_rdata = '1;
        @(negedge clk); #1;
        checks++; if (pmem_read !== 0 || pmem_write !== 0) begin errors++; $display("FAIL reset_strobes rd=%b wr=%b want 0 0", pmem_read, pmem_write); end
        checks++; if (dem_resp !== 0 || drn_resp !== 0) begin errors++; $display("FAIL idle_resp dem=%b drn=%b want 0 0", dem_resp, drn_resp); end
        checks++; if (dem_rdata !== 0) begin errors++; $display("FAIL reset_rdata got %h want 0", dem_rdata); end
        checks++; if (pmem_address !== 0 || pmem_wdata !== 0) begin errors++; $display("FAIL reset_latch addr=%h wdata=%h want 0", pmem_address, pmem_wdata); end
        pmem_resp = 0;
    endtask

    task automatic test_demand_only();
        int kind; logic [15:0] a; logic [127:0] wd, got; bit st, dr, wr;
        do_reset();
        dem_read = 1; dem_address = 16'h1230;
        serve(3, {16{8'hA5}}, 0, kind, a, wd, st, dr, wr, got);
        dem_read = 0;
        checks++; if (kind !== 1 || a !== 16'h1230) begin errors++; $display("FAIL demand_only kind=%0d addr=%h want 1 1230", kind, a); end
        checks++; if (!st || pmem_read !== 0) begin errors++; $display("FAIL demand_hold stable=%b rd_after=%b want 1 0", st, pmem_read); end
        checks++; if (dr !== 1 || wr !== 0 || got !== {16{8'hA5}}) begin errors++; $display("FAIL demand_resp dem=%b drn=%b data=%h", dr, wr, got); end
    endtask

    task automatic test_demand_then_drain();
        int kind, e; logic [15:0] a; logic [127:0] wd, got, w0; bit st, dr, wr;
        do_reset();
        w0 = {4{$urandom}};
        dem_read = 1; dem_address = 16'h2000; drn_write = 1; drn_address = 16'h3000; drn_wdata = w0; dirty_count = 2;
        e = exp_kind(1, 1, 16'h2000, 16'h3000, 2);
        serve(2, '0, 0, kind, a, wd, st, dr, wr, got);
        dem_read = 0; m_grant(e, 1);
        checks++; if (kind !== e || a !== 16'h2000) begin errors++; $display("FAIL both_first kind=%0d addr=%h want %0d 2000", kind, a, e); end
        e = exp_kind(0, 1, 16'h2000, 16'h3000, 2);
        serve(2, '0, 0, kind, a, wd, st, dr, wr, got);
        drn_write = 0; m_grant(e, 1);
        checks++; if (kind !== e || a !== 16'h3000 || wd !== w0) begin errors++; $display("FAIL both_second kind=%0d addr=%h want %0d 3000", kind, a, e); end
        checks++; if (wr !== 1 || dr !== 0 || !st) begin errors++; $display("FAIL drain_resp drn=%b dem=%b stable=%b want 1 0 1", wr, dr, st); end
    endtask

    task automatic test_starvation();
        int kind, e, n; logic [15:0] a; logic [127:0] wd, got; bit st, dr, wr;
        do_reset();
        drn_write = 1; drn_address = 16'h7000; dirty_count = 2; n = 0;
        for (int g = 0; g < 5; g++) begin
            dem_read = 1; dem_address = 16'h1000 + 16'(g * 16);
            e = exp_kind(1, 1, dem_address, 16'h7000, 2);
            serve(1 + int'($urandom % 3), '0, 0, kind, a, wd, st, dr, wr, got);
            m_grant(e, 1);
            if (kind == 1) n++;
            checks++; if (kind !== e) begin errors++; $display("FAIL starve_grant%0d got %0d want %0d", g, kind, e); end
        end
        dem_read = 0; drn_write = 0;
        checks++; if (n !== 4) begin errors++; $display("FAIL starve_count demand grants %0d want 4", n); end
    endtask

    task automatic test_hazard();
        int kind, e; logic [15:0] a; logic [127:0] wd, got; bit st, dr, wr;
        do_reset();
        dem_read = 1; dem_address = 16'h4008; drn_write = 1; drn_address = 16'h4000;
        e = exp_kind(1, 1, 16'h4008, 16'h4000, 0);
        serve(2, '0, 0, kind, a, wd, st, dr, wr, got);
        drn_write = 0; m_grant(e, 1);
        checks++; if (kind !== e || a !== 16'h4000) begin errors++; $display("FAIL hazard_first kind=%0d addr=%h want %0d 4000", kind, a, e); end
        serve(1, 128'h1, 0, kind, a, wd, st, dr, wr, got);
        dem_read = 0;
        checks++; if (kind !== 1 || a !== 16'h4008 || got !== 128'h1) begin errors++; $display("FAIL hazard_second kind=%0d addr=%h want 1 4008", kind, a); end
    endtask

    task automatic test_high_water();
        int kind, e; logic [15:0] a; logic [127:0] wd, got; bit st, dr, wr;
        int lv[3] = '{6, 5, 9};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            dem_read = 1; dem_address = 16'h2000; drn_write = 1; drn_address = 16'h3000; dirty_count = 4'(lv[i]);
            e = exp_kind(1, 1, 16'h2000, 16'h3000, lv[i]);
            serve(1, '0, 0, kind, a, wd, st, dr, wr, got);
            dem_read = 0; drn_write = 0;
            checks++; if (kind !== e) begin errors++; $display("FAIL high_water dirty=%0d got %0d want %0d", lv[i], kind, e); end
        end
    endtask

    task automatic test_reset_mid();
        int kind, e, n; bit seen; logic [15:0] a; logic [127:0] wd, got; bit st, dr, wr;
        do_reset();
        drn_write = 1; drn_address = 16'h6000; drn_wdata = {4{$urandom}}; dirty_count = 2;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = pmem_write; end
        @(negedge clk);
        rst_n = 0; pmem_resp = 1; #1;
        checks++; if (!seen || pmem_write !== 0 || drn_resp !== 0) begin errors++; $display("FAIL reset_mid_drain seen=%b wr=%b resp=%b want 1 0 0", seen, pmem_write, drn_resp); end
        repeat (2) @(negedge clk);
        pmem_resp = 0; m_starve = 0;
        dem_read = 1; dem_address = 16'h5000;
        rst_n = 1;
        for (int g = 0; g < 3; g++) begin
            e = exp_kind(1, 1, dem_address, 16'h6000, 2);
            serve(1, '0, 0, kind, a, wd, st, dr, wr, got);
            m_grant(e, 1);
            dem_address = dem_address + 16'h10;
            checks++; if (kind !== e) begin errors++; $display("FAIL prereset_grant%0d got %0d want %0d", g, kind, e); end
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = pmem_read; end
        rst_n = 0; pmem_resp = 1; #1;
        checks++; if (!seen || pmem_read !== 0 || dem_resp !== 0) begin errors++; $display("FAIL reset_mid_demand seen=%b rd=%b resp=%b want 1 0 0", seen, pmem_read, dem_resp); end
        repeat (2) @(negedge clk);
        pmem_resp = 0; m_starve = 0;
        rst_n = 1; n = 0; kind = 1;
        for (int g = 0; g < 8 && kind == 1; g++) begin
            e = exp_kind(1, 1, dem_address, 16'h6000, 2);
            serve(1, '0, 0, kind, a, wd, st, dr, wr, got);
            m_grant(e, 1);
            if (kind == 1) n++;
            dem_address = dem_address + 16'h10;
        end
        dem_read = 0; drn_write = 0;
        checks++; if (n !== 4 || kind !== 2) begin errors++; $display("FAIL post_reset_starve demand grants %0d last %0d want 4 2", n, kind); end
    endtask

    task automatic test_random();
        int kind, e, dirty; bit d, w; logic [15:0] da, wa, a; logic [127:0] wv, rd, wd, got; bit st, dr, wr;
        do_reset();
        for (int r = 0; r < 60; r++) begin
            d = 1'($urandom); w = 1'($urandom);
            if (!d && !w) d = 1;
            da = 16'($urandom);
            wa = ($urandom % 4 == 0) ? {da[15:4], 4'($urandom)} : 16'($urandom);
            dirty = int'($urandom % 10); wv = {4{$urandom}}; rd = {4{$urandom}};
            dem_read = d; drn_write = w; dem_address = da; drn_address = wa; drn_wdata = wv; dirty_count = 4'(dirty);
            e = exp_kind(d, w, da, wa, dirty);
            serve(1 + int'($urandom % 4), rd, 1, kind, a, wd, st, dr, wr, got);
            dem_read = 0; drn_write = 0;
            m_grant(e, w);
            checks++;
            if (kind !== e || a !== (e == 1 ? da : wa) || (e == 2 && wd !== wv) || !st || dr !== (e == 1) || wr !== (e == 2) || (e == 1 && got !== rd)) begin
                errors++;
                $display("FAIL random%0d kind=%0d want %0d addr=%h stable=%b dem=%b drn=%b", r, kind, e, a, st, dr, wr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_demand_only();
        test_demand_then_drain();
        test_starvation();
        test_hazard();
        test_high_water();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
